// File: rtl/frame_checker_pkg.sv
// rtl/frame_checker_pkg.sv - shared constants, register map and enums for frame_checker
package frame_checker_pkg;

  localparam logic [15:0] PREAMBLE_WORD = 16'hAAAA;
  localparam logic [15:0] SFD_WORD      = 16'hAAAB;
  localparam int          HDR_BEATS     = 12;

  localparam logic [7:0] ADDR_MAC0   = 8'd0;
  localparam logic [7:0] ADDR_CTRL   = 8'd6;
  localparam logic [7:0] ADDR_STATUS = 8'd7;
  localparam logic [7:0] ADDR_GOOD   = 8'd8;
  localparam logic [7:0] ADDR_ERR    = 8'd9;
  localparam logic [7:0] ADDR_FILT   = 8'd10;
  localparam logic [7:0] ADDR_SUM0   = 8'd11;
  localparam logic [7:0] ADDR_LEN0   = 8'd15;
  localparam logic [7:0] ADDR_TYPE0  = 8'd17;
  localparam logic [7:0] ADDR_SRC0   = 8'd19;

  typedef enum logic [1:0] {S_PRE, S_HDR, S_PAY, S_DRAIN} state_t;
  typedef enum logic [1:0] {GOOD, FILTERED, ERROR} cstat_t;

endpackage

// File: rtl/frame_checker_csr.sv
// rtl/frame_checker_csr.sv - Avalon register file, frame counters and last-frame capture
module frame_checker_csr
  import frame_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic        i_done,
  input  cstat_t      i_stat,
  input  logic [31:0] i_sum,
  input  logic [15:0] i_len,
  input  logic [15:0] i_type,
  input  logic [47:0] i_src,
  input  logic        i_in_frame,
  output logic        o_enable,
  output logic        o_filt_en,
  output logic [47:0] o_mac
);

  logic [47:0] r_mac, r_src;
  logic        r_enable, r_filt_en, r_clr, r_last_err;
  logic [7:0]  r_good, r_err, r_filt, r_rdata;
  logic [31:0] r_sum;
  logic [15:0] r_len, r_type;
  logic [7:0]  w_rmux;
  logic        w_wr;
  logic        w_unused;

  assign w_wr      = chipselect && write;
  assign w_unused  = &{1'b0, writedata[7:3]};
  assign o_enable  = r_enable;
  assign o_filt_en = r_filt_en;
  assign o_mac     = r_mac;
  assign readdata  = r_rdata;

  // clear is held one cycle so it lines up with the completion pulse of a
  // frame whose tlast shares the cycle of the clear write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mac      <= '0;
      r_enable   <= 1'b0;
      r_filt_en  <= 1'b0;
      r_clr      <= 1'b0;
      r_last_err <= 1'b0;
      r_good     <= '0;
      r_err      <= '0;
      r_filt     <= '0;
      r_sum      <= '0;
      r_len      <= '0;
      r_type     <= '0;
      r_src      <= '0;
      r_rdata    <= '0;
    end else begin
      r_clr <= 1'b0;
      if (w_wr) begin
        if (address <= 8'd5) begin
          r_mac[{address[2:0], 3'b000} +: 8] <= writedata;
        end else if (address == ADDR_CTRL) begin
          r_enable  <= writedata[0];
          r_clr     <= writedata[1];
          r_filt_en <= writedata[2];
        end
      end
      if (r_clr) begin
        r_good <= '0;
        r_err  <= '0;
        r_filt <= '0;
      end else if (i_done) begin
        case (i_stat)
          GOOD:     r_good <= r_good + 8'd1;
          FILTERED: r_filt <= r_filt + 8'd1;
          default:  r_err  <= r_err + 8'd1;
        endcase
      end
      if (i_done) begin
        r_last_err <= (i_stat == ERROR);
        if (i_stat != ERROR) begin
          r_sum  <= i_sum;
          r_len  <= i_len;
          r_type <= i_type;
          r_src  <= i_src;
        end
      end
      r_rdata <= (chipselect && read) ? w_rmux : 8'h00;
    end
  end

  always_comb begin
    w_rmux = 8'h00;
    case (address)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5:
                           w_rmux = r_mac[{address[2:0], 3'b000} +: 8];
      ADDR_CTRL:           w_rmux = {5'd0, r_filt_en, 1'b0, r_enable};
      ADDR_STATUS:         w_rmux = {6'd0, r_last_err, i_in_frame};
      ADDR_GOOD:           w_rmux = r_good;
      ADDR_ERR:            w_rmux = r_err;
      ADDR_FILT:           w_rmux = r_filt;
      ADDR_SUM0:           w_rmux = r_sum[7:0];
      ADDR_SUM0 + 8'd1:    w_rmux = r_sum[15:8];
      ADDR_SUM0 + 8'd2:    w_rmux = r_sum[23:16];
      ADDR_SUM0 + 8'd3:    w_rmux = r_sum[31:24];
      ADDR_LEN0:           w_rmux = r_len[7:0];
      ADDR_LEN0 + 8'd1:    w_rmux = r_len[15:8];
      ADDR_TYPE0:          w_rmux = r_type[7:0];
      ADDR_TYPE0 + 8'd1:   w_rmux = r_type[15:8];
      ADDR_SRC0:           w_rmux = r_src[7:0];
      ADDR_SRC0 + 8'd1:    w_rmux = r_src[15:8];
      ADDR_SRC0 + 8'd2:    w_rmux = r_src[23:16];
      ADDR_SRC0 + 8'd3:    w_rmux = r_src[31:24];
      ADDR_SRC0 + 8'd4:    w_rmux = r_src[39:32];
      ADDR_SRC0 + 8'd5:    w_rmux = r_src[47:40];
      default:             w_rmux = 8'h00;
    endcase
  end

endmodule

// File: rtl/frame_checker.sv
// rtl/frame_checker.sv - 16-bit stream frame parser with length check, dst filter and payload sum
module frame_checker
  import frame_checker_pkg::*;
#(
  parameter int MAX_PAYLOAD      = 1500,
  parameter bit BROADCAST_ACCEPT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  output logic        ingress_port_tready,
  input  logic        ingress_port_tvalid
);

  localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] LEN_BEAT  = 16'd10;
  localparam logic [15:0] TYPE_BEAT = 16'(HDR_BEATS - 1);

  state_t      r_state;
  cstat_t      r_stat;
  logic        r_done;
  logic [15:0] r_beat, r_len, r_type, r_rem;
  logic [47:0] r_dst, r_src;
  logic [31:0] r_sum;

  logic        w_enable, w_filt_en, w_fire, w_filtered, w_last_pay, w_in_frame;
  logic [47:0] w_mac;
  logic [15:0] w_swap, w_exp_pre;
  logic [31:0] w_add;
  cstat_t      w_pass_stat;

  assign ingress_port_tready = w_enable;
  assign w_fire      = ingress_port_tvalid && w_enable;
  // header fields carry byte 0 in [15:8]; swap so byte 0 lands in the low lane
  assign w_swap      = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
  assign w_exp_pre   = (r_beat == 16'd3) ? SFD_WORD : PREAMBLE_WORD;
  assign w_filtered  = w_filt_en && (r_dst != w_mac) && !(BROADCAST_ACCEPT && (&r_dst));
  assign w_pass_stat = w_filtered ? FILTERED : GOOD;
  assign w_last_pay  = (r_rem <= 16'd2);
  assign w_add       = {24'd0, ingress_port_tdata[15:8]}
                     + ((r_rem >= 16'd2) ? {24'd0, ingress_port_tdata[7:0]} : 32'd0);
  assign w_in_frame  = (r_state != S_PRE) || (r_beat != 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_PRE;
      r_stat  <= GOOD;
      r_done  <= 1'b0;
      r_beat  <= '0;
      r_len   <= '0;
      r_type  <= '0;
      r_rem   <= '0;
      r_dst   <= '0;
      r_src   <= '0;
      r_sum   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_fire) begin
        r_beat <= r_beat + 16'd1;
        case (r_state)
          S_PRE: begin
            if (r_beat == 16'd0) r_sum <= '0;
            if (ingress_port_tlast) begin
              r_done <= 1'b1;
              r_stat <= ERROR;
              r_beat <= '0;
            end else if (ingress_port_tdata != w_exp_pre) begin
              r_state <= S_DRAIN;
            end else if (r_beat == 16'd3) begin
              r_state <= S_HDR;
            end
          end
          S_HDR: begin
            case (r_beat)
              16'd4:     r_dst[15:0]  <= w_swap;
              16'd5:     r_dst[31:16] <= w_swap;
              16'd6:     r_dst[47:32] <= w_swap;
              16'd7:     r_src[15:0]  <= w_swap;
              16'd8:     r_src[31:16] <= w_swap;
              16'd9:     r_src[47:32] <= w_swap;
              LEN_BEAT:  begin
                r_len <= w_swap;
                r_rem <= w_swap;
              end
              TYPE_BEAT: r_type <= w_swap;
              default:   ;
            endcase
            if (r_beat == TYPE_BEAT && r_len == 16'd0) begin
              if (ingress_port_tlast) begin
                r_done  <= 1'b1;
                r_stat  <= w_pass_stat;
                r_state <= S_PRE;
                r_beat  <= '0;
              end else begin
                r_state <= S_DRAIN;
              end
            end else if (ingress_port_tlast) begin
              r_done  <= 1'b1;
              r_stat  <= ERROR;
              r_state <= S_PRE;
              r_beat  <= '0;
            end else if (r_beat == LEN_BEAT && w_swap > MAX_LEN) begin
              r_state <= S_DRAIN;
            end else if (r_beat == TYPE_BEAT) begin
              r_state <= S_PAY;
            end
          end
          S_PAY: begin
            r_sum <= r_sum + w_add;
            r_rem <= r_rem - ((r_rem >= 16'd2) ? 16'd2 : 16'd1);
            if (w_last_pay) begin
              if (ingress_port_tlast) begin
                r_done  <= 1'b1;
                r_stat  <= w_pass_stat;
                r_state <= S_PRE;
                r_beat  <= '0;
              end else begin
                r_state <= S_DRAIN;
              end
            end else if (ingress_port_tlast) begin
              r_done  <= 1'b1;
              r_stat  <= ERROR;
              r_state <= S_PRE;
              r_beat  <= '0;
            end
          end
          default: begin
            if (ingress_port_tlast) begin
              r_done  <= 1'b1;
              r_stat  <= ERROR;
              r_state <= S_PRE;
              r_beat  <= '0;
            end
          end
        endcase
      end
    end
  end

  frame_checker_csr u_csr (
    .clk        (clk),
    .reset      (reset),
    .writedata  (writedata),
    .write      (write),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .i_done     (r_done),
    .i_stat     (r_stat),
    .i_sum      (r_sum),
    .i_len      (r_len),
    .i_type     (r_type),
    .i_src      (r_src),
    .i_in_frame (w_in_frame),
    .o_enable   (w_enable),
    .o_filt_en  (w_filt_en),
    .o_mac      (w_mac)
  );

endmodule

// File: tb/tb_frame_checker.sv
// tb/tb_frame_checker.sv - randomized self-checking bench for frame_checker
`timescale 1ns/1ps
module tb_frame_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  writedata = '0, address = '0;
  logic        write = 1'b0, chipselect = 1'b0, read = 1'b0;
  logic [7:0]  readdata;
  logic [15:0] tdata = '0;
  logic        tlast = 1'b0, tvalid = 1'b0;
  logic        tready;

  int errors = 0;
  int checks = 0;
  bit gaps = 1'b0;

  logic [15:0] fq[$];
  logic [7:0]  pl[$];

  logic [47:0] m_mac, m_src;
  logic        m_filt_en, m_last_err;
  logic [7:0]  m_good, m_err, m_filt;
  logic [31:0] m_sum;
  logic [15:0] m_len, m_type;

  logic [7:0]  rd_good, rd_err, rd_filt, rd_status, rd_b;
  logic [31:0] rd_sum;
  logic [15:0] rd_len, rd_type;
  logic [47:0] rd_src;

  always #5 clk = ~clk;

  frame_checker dut (
    .clk                 (clk),
    .reset               (reset),
    .writedata           (writedata),
    .write               (write),
    .chipselect          (chipselect),
    .address             (address),
    .read                (read),
    .readdata            (readdata),
    .ingress_port_tdata  (tdata),
    .ingress_port_tlast  (tlast),
    .ingress_port_tready (tready),
    .ingress_port_tvalid (tvalid)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  function automatic logic [143:0] got_vec();
    return {rd_good, rd_err, rd_filt, rd_status, rd_sum, rd_len, rd_type, rd_src};
  endfunction

  function automatic logic [143:0] exp_vec();
    return {m_good, m_err, m_filt, 6'd0, m_last_err, 1'b0, m_sum, m_len, m_type, m_src};
  endfunction

  task automatic model_reset();
    m_mac = '0; m_src = '0; m_filt_en = 1'b0; m_last_err = 1'b0;
    m_good = '0; m_err = '0; m_filt = '0; m_sum = '0; m_len = '0; m_type = '0;
  endtask

  // Reference: judge the whole frame by its word list, independent of beat timing
  task automatic model_frame();
    int n = fq.size();
    bit bad = 1'b0;
    int len = 0;
    logic [47:0] dst, src;
    logic [31:0] sum = '0;
    logic [15:0] w;
    for (int i = 0; i < 4; i++)
      if (i >= n || fq[i] !== ((i == 3) ? 16'hAAAB : 16'hAAAA)) bad = 1'b1;
    if (n < 12) bad = 1'b1;
    else begin
      w = fq[10];
      len = int'({w[7:0], w[15:8]});
      if (len > 1500 || n != 12 + (len + 1) / 2) bad = 1'b1;
    end
    if (bad) begin
      m_err++;
      m_last_err = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        w = fq[4 + k]; dst[16*k +: 8] = w[15:8]; dst[16*k + 8 +: 8] = w[7:0];
        w = fq[7 + k]; src[16*k +: 8] = w[15:8]; src[16*k + 8 +: 8] = w[7:0];
      end
      for (int i = 0; i < len; i++) begin
        w = fq[12 + i / 2];
        sum += (i % 2 == 0) ? 32'(w[15:8]) : 32'(w[7:0]);
      end
      if (m_filt_en && dst !== m_mac && dst !== 48'hFFFF_FFFF_FFFF) m_filt++;
      else m_good++;
      w = fq[11];
      m_sum = sum; m_len = 16'(len); m_type = {w[7:0], w[15:8]}; m_src = src;
      m_last_err = 1'b0;
    end
  endtask

  // all bus tasks are entered and left at a falling edge
  task automatic csr_write(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic set_mac(input logic [47:0] mac);
    for (int k = 0; k < 6; k++) csr_write(8'(k), mac[8*k +: 8]);
    m_mac = mac;
  endtask

  task automatic set_ctrl(input logic en, input logic filt);
    csr_write(8'd6, {5'd0, filt, 1'b0, en});
    m_filt_en = filt;
  endtask

  task automatic read_snap();
    logic [7:0] b;
    csr_read(8'd7, rd_status);
    csr_read(8'd8, rd_good);
    csr_read(8'd9, rd_err);
    csr_read(8'd10, rd_filt);
    for (int k = 0; k < 4; k++) begin csr_read(8'(11 + k), b); rd_sum[8*k +: 8] = b; end
    for (int k = 0; k < 2; k++) begin csr_read(8'(15 + k), b); rd_len[8*k +: 8] = b; end
    for (int k = 0; k < 2; k++) begin csr_read(8'(17 + k), b); rd_type[8*k +: 8] = b; end
    for (int k = 0; k < 6; k++) begin csr_read(8'(19 + k), b); rd_src[8*k +: 8] = b; end
  endtask

  task automatic set_pl(input logic [31:0] v, input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(v[8*(n - 1 - i) +: 8]);
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] len, input logic [15:0] typ, input int npay);
    fq.delete();
    repeat (3) fq.push_back(16'hAAAA);
    fq.push_back(16'hAAAB);
    for (int k = 0; k < 3; k++) fq.push_back({dst[16*k +: 8], dst[16*k + 8 +: 8]});
    for (int k = 0; k < 3; k++) fq.push_back({src[16*k +: 8], src[16*k + 8 +: 8]});
    fq.push_back({len[7:0], len[15:8]});
    fq.push_back({typ[7:0], typ[15:8]});
    while (pl.size() < 2 * npay) pl.push_back(8'($urandom()));
    for (int j = 0; j < npay; j++) fq.push_back({pl[2*j], pl[2*j + 1]});
    pl.delete();
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int g = 0;
    if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = l;
    while (tready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL tready_timeout: tready=%b required 1", tready);
    end
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_beat(fq[i], i == fq.size() - 1);
  endtask

  task automatic run_frame();
    send_range(0, fq.size());
    model_frame();
    repeat (2) @(negedge clk);
    read_snap();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b required 0", tready); end
    read_snap();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL reset_regs: got %h required %h", got_vec(), exp_vec()); end
    csr_read(8'd6, rd_b);
    checks++;
    if (rd_b !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", rd_b); end
  endtask

  task automatic test_good();
    set_mac(48'h060504030201);
    set_ctrl(1'b1, 1'b1);
    set_pl(32'h11223344, 4);
    build_frame(48'h060504030201, 48'h0C0B0A090807, 16'd4, 16'h0800, 2);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL good_frame: got %h required %h", got_vec(), exp_vec()); end
    checks++;
    if (rd_good !== 8'd1 || rd_sum !== 32'hAA || rd_len !== 16'd4) begin
      errors++; $display("FAIL good_fields: got good=%0d sum=%h len=%h required 1 000000aa 0004", rd_good, rd_sum, rd_len);
    end
  endtask

  task automatic test_zero_odd();
    build_frame(48'h060504030201, 48'h112233445566, 16'd0, 16'h86DD, 0);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec() || rd_sum !== 32'd0) begin errors++; $display("FAIL zero_len: got %h required %h", got_vec(), exp_vec()); end
    set_pl(32'h010203FF, 4);
    build_frame(48'h060504030201, 48'h112233445566, 16'd3, 16'h0801, 2);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec() || rd_sum !== 32'd6) begin errors++; $display("FAIL odd_len: got %h required %h", got_vec(), exp_vec()); end
  endtask

  task automatic test_short();
    build_frame(48'h060504030201, 48'hA1A2A3A4A5A6, 16'd6, 16'h0900, 2);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec() || rd_sum !== 32'd6 || rd_len !== 16'd3) begin
      errors++; $display("FAIL short_frame: got %h required %h", got_vec(), exp_vec());
    end
    build_frame(48'h060504030201, 48'hA1A2A3A4A5A6, 16'd6, 16'h0900, 3);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL after_short: got %h required %h", got_vec(), exp_vec()); end
  endtask

  task automatic test_bad_pre();
    fq.delete();
    fq.push_back(16'hAAAA);
    fq.push_back(16'h5555);
    repeat (8) fq.push_back(16'($urandom()));
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL bad_preamble: got %h required %h", got_vec(), exp_vec()); end
    build_frame(48'h060504030201, 48'h0A0B0C0D0E0F, 16'd1500, 16'h0800, 750);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL max_len: got %h required %h", got_vec(), exp_vec()); end
    build_frame(48'h060504030201, 48'h0A0B0C0D0E0F, 16'd1501, 16'h0800, 751);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL over_len: got %h required %h", got_vec(), exp_vec()); end
  endtask

  task automatic test_filter();
    build_frame(48'h070504030201, 48'h010101010101, 16'd2, 16'h0800, 1);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL filt_drop: got %h required %h", got_vec(), exp_vec()); end
    build_frame(48'hFFFFFFFFFFFF, 48'h020202020202, 16'd5, 16'h0806, 3);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL filt_bcast: got %h required %h", got_vec(), exp_vec()); end
    set_ctrl(1'b1, 1'b0);
    build_frame(48'h070504030201, 48'h030303030303, 16'd2, 16'h0800, 1);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL filt_off: got %h required %h", got_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    logic [47:0] dst;
    int len, npay, sel;
    gaps = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) set_ctrl(1'b1, 1'($urandom_range(0, 1)));
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? m_mac : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {16'($urandom()), $urandom()};
      len = $urandom_range(0, 40);
      npay = (len + 1) / 2;
      sel = $urandom_range(0, 7);
      if (sel == 0) npay = npay + 1;
      else if (sel == 1 && npay > 0) npay = npay - 1;
      build_frame(dst, {16'($urandom()), $urandom()}, 16'(len), 16'($urandom()), npay);
      if ($urandom_range(0, 9) == 0) fq[$urandom_range(0, 3)] ^= 16'h0100;
      run_frame();
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random_%0d: got %h required %h", it, got_vec(), exp_vec()); end
    end
    gaps = 1'b0;
  endtask

  task automatic test_control();
    int bad_rdy = 0;
    set_ctrl(1'b0, m_filt_en);
    tvalid = 1'b1; tdata = 16'hAAAA; tlast = 1'b0;
    repeat (5) begin @(negedge clk); if (tready !== 1'b0) bad_rdy++; end
    tvalid = 1'b0;
    csr_read(8'd7, rd_b);
    checks++;
    if (bad_rdy != 0 || rd_b[0] !== 1'b0) begin errors++; $display("FAIL disabled: tready_high=%0d in_frame=%b required 0 0", bad_rdy, rd_b[0]); end

    set_ctrl(1'b1, m_filt_en);
    build_frame(m_mac, 48'h445566778899, 16'd6, 16'h0800, 3);
    send_range(0, 6);
    set_ctrl(1'b0, m_filt_en);
    csr_read(8'd7, rd_b);
    checks++;
    if (tready !== 1'b0 || rd_b[0] !== 1'b1) begin errors++; $display("FAIL pause: tready=%b in_frame=%b required 0 1", tready, rd_b[0]); end
    set_ctrl(1'b1, m_filt_en);
    run_frame_tail();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL resume: got %h required %h", got_vec(), exp_vec()); end

    build_frame(m_mac, 48'h0F0E0D0C0B0A, 16'd4, 16'h0800, 2);
    send_range(0, fq.size() - 1);
    tvalid = 1'b1; tdata = fq[fq.size() - 1]; tlast = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'd6; writedata = {5'd0, m_filt_en, 2'b11};
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; write = 1'b0;
    model_frame();
    m_good = '0; m_err = '0; m_filt = '0;
    repeat (2) @(negedge clk);
    read_snap();
    checks++;
    if (got_vec() !== exp_vec() || rd_good !== 8'd0) begin errors++; $display("FAIL clear_on_tlast: got %h required %h", got_vec(), exp_vec()); end

    build_frame(m_mac, 48'h0F0E0D0C0B0A, 16'd8, 16'h0800, 4);
    fq[13] = 16'h1234;
    send_range(0, 13);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL midreset_tready: got %b required 0", tready); end
    read_snap();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL midreset_regs: got %h required %h", got_vec(), exp_vec()); end
    set_mac(48'h060504030201);
    set_ctrl(1'b1, 1'b1);
    repeat (13) void'(fq.pop_front());
    run_frame();
    checks++;
    if (got_vec() !== exp_vec() || rd_err !== 8'd1) begin errors++; $display("FAIL residual: got %h required %h", got_vec(), exp_vec()); end
    build_frame(m_mac, 48'h5A5A5A5A5A5A, 16'd7, 16'h0800, 4);
    run_frame();
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL recover: got %h required %h", got_vec(), exp_vec()); end
  endtask

  task automatic run_frame_tail();
    send_range(6, fq.size());
    model_frame();
    repeat (2) @(negedge clk);
    read_snap();
  endtask

  initial begin
    test_reset();
    test_good();
    test_zero_odd();
    test_short();
    test_bad_pre();
    test_filter();
    test_random();
    test_control();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
